// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU, branch and mul/div selects plus the mul/div FSM states.
// No logic of its own; no latency.
// No flow control here; consumers own their handshakes.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } branch_op_e;

    // Bit 0 set selects the upper half of the 2*W working register (MULHU high word, REMU remainder).
    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Counter value of the final iterative step (32 steps total).
    localparam logic [4:0] MD_LAST_STEP = 5'd31;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Latency: accept cycle + 32 BUSY cycles + 1 DONE cycle in which the result is presented.
// Backpressure: mem_stall freezes FSM, counter and datapath; busy stays high through BUSY.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mem_stall,
    input  logic [1:0]       op,
    input  logic [BIT_W-1:0] a,
    input  logic [BIT_W-1:0] b,
    input  logic [4:0]       rd_in,
    input  logic             regwr_in,
    output logic             busy,
    output logic             done,
    output logic [BIT_W-1:0] result,
    output logic [4:0]       rd,
    output logic             regwr
);

    md_state_e          state, state_nxt;
    logic [4:0]         cnt;
    logic [1:0]         op_q;
    logic [BIT_W-1:0]   opnd_q;   // multiplicand for MUL*, divisor for DIV*
    logic [2*BIT_W-1:0] prod;     // {hi, lo}: product, or {remainder, quotient}
    logic               accept;

    logic [BIT_W:0]     mul_sum;
    logic [BIT_W:0]     div_shift;
    logic [BIT_W:0]     div_diff;
    logic [2*BIT_W-1:0] step_nxt;

    // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
    // A zero divisor never underflows, so the quotient fills with ones and the remainder ends as the dividend.
    always_comb begin
        mul_sum   = {1'b0, prod[2*BIT_W-1:BIT_W]} + (prod[0] ? {1'b0, opnd_q} : '0);
        div_shift = {prod[2*BIT_W-1:BIT_W], prod[BIT_W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!op_q[1]) begin
            step_nxt = {mul_sum, prod[BIT_W-1:1]};
        end else if (div_diff[BIT_W]) begin
            step_nxt = {div_shift[BIT_W-1:0], prod[BIT_W-2:0], 1'b0};
        end else begin
            step_nxt = {div_diff[BIT_W-1:0], prod[BIT_W-2:0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; busy is forced low while reset is asserted.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && !mem_stall) begin
                    accept    = 1'b1;
                    busy      = 1'b1;
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (!mem_stall && cnt == MD_LAST_STEP) state_nxt = MD_DONE;
            end
            MD_DONE: begin
                done = 1'b1;
                if (!mem_stall) state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
        if (!rst_n) busy = 1'b0;
    end

    // Operand capture on accept, one step per unstalled BUSY cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            opnd_q <= '0;
            prod   <= '0;
            rd     <= '0;
            regwr  <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= op;
            opnd_q <= op[1] ? b : a;
            prod   <= {{BIT_W{1'b0}}, (op[1] ? a : b)};
            rd     <= rd_in;
            regwr  <= regwr_in;
        end else if (state == MD_BUSY && !mem_stall) begin
            cnt  <= cnt + 5'd1;
            prod <= step_nxt;
        end
    end

    assign result = op_q[0] ? prod[2*BIT_W-1:BIT_W] : prod[BIT_W-1:0];

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch resolution and EX/MEM register; optional iterative mul/div under RV32M_MULDIV_EN.
// Latency: 1 cycle for ALU/jump ops; 34 cycles for mul/div; branch redirect is combinational.
// Backpressure: mem_stall holds EX/MEM; ex_busy asks upstream to hold ID/EX while a mul/div runs.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIT_W-1:0] rs1_data,
    input  logic [BIT_W-1:0] rs2_data,
    input  logic [BIT_W-1:0] imm,
    input  logic [BIT_W-1:0] PC,
    input  logic [3:0]       alu_op,
    input  logic [2:0]       branch_op,
    input  logic [1:0]       muldiv_op,
    input  logic             valid,
    input  logic             alu_src_imm,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic             is_muldiv,
    input  logic             memrd_in,
    input  logic             memwr_in,
    input  logic             mem2reg_in,
    input  logic             regwr_in,
    input  logic [4:0]       rd_in,
    input  logic             mem_stall,
    output logic [BIT_W-1:0] alu_result_out,
    output logic [BIT_W-1:0] mem_wdata_out,
    output logic [BIT_W-1:0] PC_plus_4_out,
    output logic             memrd_out,
    output logic             memwr_out,
    output logic             mem2reg_out,
    output logic             regwr_out,
    output logic [4:0]       rd_out,
    output logic             branch_taken,
    output logic [BIT_W-1:0] branch_target,
    output logic             ex_busy
);

    logic [BIT_W-1:0] op_b;
    logic [BIT_W-1:0] alu_res;
    logic [BIT_W-1:0] pc_plus_4;
    logic [BIT_W-1:0] jalr_sum;
    logic [4:0]       shamt;
    logic             lt_s, lt_u, eq, cond;
    logic             ctl_ok;

    logic             md_done;
    logic [BIT_W-1:0] md_result;
    logic [4:0]       md_rd;
    logic             md_regwr;

    assign op_b      = alu_src_imm ? imm : rs2_data;
    assign shamt     = op_b[4:0];
    assign pc_plus_4 = PC + BIT_W'(4);
    assign jalr_sum  = rs1_data + imm;
    assign lt_s      = $signed(rs1_data) < $signed(rs2_data);
    assign lt_u      = rs1_data < rs2_data;
    assign eq        = rs1_data == rs2_data;

    // ALU: all arithmetic wraps at BIT_W bits.
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(alu_op))
            ALU_ADD:  alu_res = rs1_data + op_b;
            ALU_SUB:  alu_res = rs1_data - op_b;
            ALU_AND:  alu_res = rs1_data & op_b;
            ALU_OR:   alu_res = rs1_data | op_b;
            ALU_XOR:  alu_res = rs1_data ^ op_b;
            ALU_SLL:  alu_res = rs1_data << shamt;
            ALU_SRL:  alu_res = rs1_data >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(rs1_data) >>> shamt);
            ALU_SLT:  alu_res = {{(BIT_W-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(BIT_W-1){1'b0}}, (rs1_data < op_b)};
            default:  alu_res = '0;
        endcase
    end

    // Branch condition always compares the two register operands, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (branch_op_e'(branch_op))
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_BLT:  cond = lt_s;
            BR_BGE:  cond = !lt_s;
            BR_BLTU: cond = lt_u;
            BR_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = valid & (jal | jalr | (branch & cond));
    assign branch_target = jalr ? {jalr_sum[BIT_W-1:1], 1'b0} : (PC + imm);

`ifdef RV32M_MULDIV_EN
    muldiv_unit #(.BIT_W(BIT_W)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (valid & is_muldiv),
        .mem_stall (mem_stall),
        .op        (muldiv_op),
        .a         (rs1_data),
        .b         (rs2_data),
        .rd_in     (rd_in),
        .regwr_in  (regwr_in),
        .busy      (ex_busy),
        .done      (md_done),
        .result    (md_result),
        .rd        (md_rd),
        .regwr     (md_regwr)
    );
`else
    // Without the mul/div option a mul/div instruction simply retires as a bubble.
    logic unused_muldiv_op;
    assign unused_muldiv_op = ^muldiv_op;
    assign ex_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign md_rd     = '0;
    assign md_regwr  = 1'b0;
`endif

    // Only a valid, non-mul/div instruction with no mul/div in flight may write controls.
    assign ctl_ok = valid & !is_muldiv & !ex_busy;

    // EX/MEM register: hold on mem_stall, mul/div result in DONE, otherwise normal or bubble load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_result_out <= '0;
            mem_wdata_out  <= '0;
            PC_plus_4_out  <= '0;
            memrd_out      <= 1'b0;
            memwr_out      <= 1'b0;
            mem2reg_out    <= 1'b0;
            regwr_out      <= 1'b0;
            rd_out         <= '0;
        end else if (!mem_stall) begin
            PC_plus_4_out <= pc_plus_4;
            mem_wdata_out <= rs2_data;
            if (md_done) begin
                alu_result_out <= md_result;
                rd_out         <= md_rd;
                regwr_out      <= md_regwr;
                memrd_out      <= 1'b0;
                memwr_out      <= 1'b0;
                mem2reg_out    <= 1'b0;
            end else begin
                alu_result_out <= (jal | jalr) ? pc_plus_4 : alu_res;
                rd_out         <= rd_in;
                regwr_out      <= regwr_in & ctl_ok;
                memrd_out      <= memrd_in & ctl_ok;
                memwr_out      <= memwr_in & ctl_ok;
                mem2reg_out    <= mem2reg_in & ctl_ok;
            end
        end
    end

endmodule
